// File: rtl/dashcam_arb_pkg.sv
// Shared types and constants for the dashcam frame-memory arbiter.
// Optional slave timeout is built in with DASHCAM_ARB_TIMEOUT_EN.
package dashcam_arb_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int MST_DMA     = 0;
  localparam int MST_SD      = 1;
  localparam int MST_HOST    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_RELEASE
  } arb_state_e;

  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      oh[1]:   idx = 2'd1;
      oh[2]:   idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/dashcam_mem_arbiter_picker.sv
// Three-way round-robin picker: search starts at ptr, wraps modulo 3.
// Produces a one-hot winner, or zero when nothing requests.
module dashcam_rr_picker
  import dashcam_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win
);

  always_comb begin
    win = '0;
    case (ptr)
      2'd1: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/dashcam_mem_arbiter.sv
// Wishbone 3:1 round-robin arbiter in front of the dashcam frame memory.
// Define DASHCAM_ARB_TIMEOUT_EN to add the slave-ack timeout watchdog.
module dashcam_mem_arbiter
  import dashcam_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    m_cyc_i,
  input  logic [2:0]    m_stb_i,
  input  logic [2:0]    m_we_i,
  input  logic [11:0]   m_sel_i,
  input  logic [3*AW-1:0] m_adr_i,
  input  logic [3*DW-1:0] m_dat_i,
  output logic [DW-1:0] m_dat_o,
  output logic [2:0]    m_ack_o,
  output logic [2:0]    m_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [2:0]    grant_o,
  output logic          timeout_o,
  input  logic          timeout_clr_i,
  output logic [15:0]   xfer_count_o
);

  arb_state_e  state_q, state_nx;
  logic [2:0]  grant_q, grant_nx;
  logic [1:0]  own_q;
  logic [1:0]  ptr_q;
  logic [15:0] xfer_q;
  logic [2:0]  win;
  logic [1:0]  win_idx;
  logic        own;
  logic        acked;
  logic        to_fire;
  logic        take;

  dashcam_rr_picker u_picker (
    .req (m_cyc_i),
    .ptr (ptr_q),
    .win (win)
  );

  assign win_idx = oh2idx(win);
  assign own     = (state_q == ST_OWN);
  assign take    = (state_q == ST_IDLE) && (|m_cyc_i);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own) begin
      unique case (own_q)
        2'd1: begin
          s_cyc_o = m_cyc_i[1];
          s_stb_o = m_cyc_i[1] & m_stb_i[1];
          s_we_o  = m_we_i[1];
          s_sel_o = m_sel_i[7:4];
          s_adr_o = m_adr_i[AW +: AW];
          s_dat_o = m_dat_i[DW +: DW];
        end
        2'd2: begin
          s_cyc_o = m_cyc_i[2];
          s_stb_o = m_cyc_i[2] & m_stb_i[2];
          s_we_o  = m_we_i[2];
          s_sel_o = m_sel_i[11:8];
          s_adr_o = m_adr_i[2*AW +: AW];
          s_dat_o = m_dat_i[2*DW +: DW];
        end
        default: begin
          s_cyc_o = m_cyc_i[0];
          s_stb_o = m_cyc_i[0] & m_stb_i[0];
          s_we_o  = m_we_i[0];
          s_sel_o = m_sel_i[3:0];
          s_adr_o = m_adr_i[0 +: AW];
          s_dat_o = m_dat_i[0 +: DW];
        end
      endcase
    end
  end

  // Stray acks outside an owned strobe never reach a master
  assign acked   = own & s_stb_o & s_ack_i;
  assign m_ack_o = acked ? grant_q : 3'b000;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign xfer_count_o = xfer_q;

  always_comb begin
    state_nx = state_q;
    grant_nx = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_nx = ST_OWN;
          grant_nx = win;
        end
      end
      ST_OWN: begin
        if (!m_cyc_i[own_q] || to_fire) begin
          state_nx = ST_RELEASE;
          grant_nx = '0;
        end
      end
      ST_RELEASE: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_nx;
      grant_q <= grant_nx;
      if (take) begin
        own_q <= win_idx;
        ptr_q <= next_ptr(win_idx);
      end
      if (acked) xfer_q <= xfer_q + 16'd1;
    end
  end

`ifdef DASHCAM_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        to_q;

  // Fires on the TIMEOUT-th consecutive stalled strobe cycle
  assign to_fire = own & s_stb_o & ~s_ack_i &
                   (tcnt_q == 16'(TIMEOUT - 1));
  assign m_err_o   = to_fire ? grant_q : 3'b000;
  assign timeout_o = to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (!own || s_ack_i || to_fire) tcnt_q <= '0;
      else if (s_stb_o)               tcnt_q <= tcnt_q + 16'd1;
      if (to_fire)            to_q <= 1'b1;
      else if (timeout_clr_i) to_q <= 1'b0;
    end
  end
`else
  logic [16:0] unused_to;

  assign to_fire   = 1'b0;
  assign m_err_o   = 3'b000;
  assign timeout_o = 1'b0;
  assign unused_to = {timeout_clr_i, 16'(TIMEOUT)};
`endif

endmodule
